// File: rtl/p_div_pkg.sv
// Shared widths, FSM encodings and iteration helper for the p_div restoring divider.
package p_div_pkg;

  localparam int unsigned DW    = 96;
  localparam int unsigned VW    = 48;
  localparam int unsigned PW    = VW + 1;
  localparam int unsigned CNT_W = 7;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int unsigned n_iter(input int unsigned r);
    return DW / r;
  endfunction

endpackage

// File: rtl/p_div_step.sv
// One combinational restoring-division step: shift P:Q left by one, subtract D when it fits.
module p_div_step
  import p_div_pkg::*;
(
  input  logic [PW-1:0] p_i,
  input  logic [DW-1:0] q_i,
  input  logic [VW-1:0] d_i,
  output logic [PW-1:0] p_o,
  output logic [DW-1:0] q_o
);

  logic [PW:0] p_sh;

  // P stays below D, so the top bit is always zero; keeping it in the compare is harmless.
  always_comb begin
    p_sh = {p_i, q_i[DW-1]};
    q_o  = {q_i[DW-2:0], 1'b0};
    p_o  = PW'(p_sh);
    if (p_sh >= (PW + 1)'(d_i)) begin
      p_o    = PW'(p_sh - (PW + 1)'(d_i));
      q_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/p_div.sv
// Iterative unsigned 96/48 restoring divider retiring R quotient bits per cycle,
// with a valid/ready operand handshake and a single-cycle masked result pulse.
module p_div
  import p_div_pkg::*;
#(
  parameter int unsigned R = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [95:0]   dividend,
  input  logic [47:0]   divisor,
  output logic          out_valid,
  output logic [95:0]   quotient,
  output logic [47:0]   remainder,
  output logic          div_zero
);

  localparam int unsigned N = n_iter(R);

  if (R == 0 || (DW % R) != 0) begin : g_bad_r
    $error("p_div: R must divide 96");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]       p_q, p_d;
  logic [DW-1:0]       q_q, q_d;
  logic [VW-1:0]       d_q, d_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       quotient_q, quotient_d;
  logic [VW-1:0]       remainder_q, remainder_d;
  logic                div_zero_q, div_zero_d;
  logic [PW-1:0]       p_calc;
  logic [DW-1:0]       q_calc;

  // R chained restoring steps evaluated within one CALC cycle.
  for (genvar i = 0; i < int'(R); i++) begin : g_step
    logic [PW-1:0] p_in, p_out;
    logic [DW-1:0] q_in, q_out;
    if (i == 0) begin : g_first
      assign p_in = p_q;
      assign q_in = q_q;
    end else begin : g_next
      assign p_in = g_step[i-1].p_out;
      assign q_in = g_step[i-1].q_out;
    end
    p_div_step u_step (
      .p_i (p_in),
      .q_i (q_in),
      .d_i (d_q),
      .p_o (p_out),
      .q_o (q_out)
    );
  end

  assign p_calc = g_step[R-1].p_out;
  assign q_calc = g_step[R-1].q_out;

  // Next state; result outputs are loaded only on the transition into DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    out_valid_d = 1'b0;
    quotient_d  = '0;
    remainder_d = '0;
    div_zero_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          q_d   = dividend;
          d_d   = divisor;
          p_d   = '0;
          cnt_d = CNT_W'(N - 1);
          if (divisor == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[VW-1:0];
            div_zero_d  = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d   = p_calc;
        q_d   = q_calc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          quotient_d  = q_calc;
          remainder_d = p_calc[VW-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_p_div.sv
// Directed and reference-checked bench for p_div (R=2, N=48).
module tb_p_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] dividend;
  logic [47:0] divisor;
  logic        out_valid;
  logic [95:0] quotient;
  logic [47:0] remainder;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;

  p_div #(.R(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [95:0] a, input logic [47:0] b,
                        input logic [95:0] eq, input logic [47:0] er, input logic edz,
                        input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, 96'(in_ready), 96'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = '1;
    divisor  = 48'd3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 96'(in_ready), 96'd0);
    end while (!out_valid && lat < 200);
    chk({tag, "_lat"}, 96'(lat), 96'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, 96'(remainder), 96'(er));
    chk({tag, "_dz"}, 96'(div_zero), 96'(edz));
    @(negedge clk);
    chk({tag, "_after"}, 96'({in_ready, out_valid}), 96'd2);
  endtask

  initial begin
    logic [95:0] ops_a [3];
    logic [47:0] ops_b [3];
    logic [95:0] ops_q [3];
    logic [47:0] ops_r [3];
    int issued, got, last, cyc, pulses;
    logic [95:0] ra, rq;
    logic [47:0] rb, rr;

    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 96'(in_ready), 96'd1);
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_q", quotient, 96'd0);
    chk("rst_r", 96'(remainder), 96'd0);
    chk("rst_dz", 96'(div_zero), 96'd0);
    rst = 1'b0;

    run_op("d56_7", 96'd56, 48'd7, 96'd8, 48'd0, 1'b0, 49);
    run_op("d100_7", 96'd100, 48'd7, 96'd14, 48'd2, 1'b0, 49);
    run_op("max_1", '1, 48'd1, '1, 48'd0, 1'b0, 49);
    run_op("sq", 96'hFFFF_FFFF_FFFE_0000_0000_0001, 48'hFFFF_FFFF_FFFF,
           96'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 49);
    run_op("max_m", '1, 48'hFFFF_FFFF_FFFF, 96'h1_0000_0000_0001, 48'd0, 1'b0, 49);
    run_op("dz", 96'h1234_0000_0000_ABCD_0000_0001, 48'd0, '1,
           48'hABCD_0000_0001, 1'b1, 1);

    // in_valid held high; only operands present while in_ready is high get accepted
    ops_a[0] = 96'd56;           ops_b[0] = 48'd7;  ops_q[0] = 96'd8;         ops_r[0] = 48'd0;
    ops_a[1] = 96'd1000;         ops_b[1] = 48'd3;  ops_q[1] = 96'd333;       ops_r[1] = 48'd1;
    ops_a[2] = 96'h1_0000_0000;  ops_b[2] = 48'd10; ops_q[2] = 96'd429496729; ops_r[2] = 48'd6;
    @(negedge clk);
    chk("b2b_ready", 96'(in_ready), 96'd1);
    in_valid = 1'b1; dividend = ops_a[0]; divisor = ops_b[0];
    issued = 1; got = 0; last = 0; cyc = 0;
    while (got < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("b2b_q", quotient, ops_q[got]);
        chk("b2b_r", 96'(remainder), 96'(ops_r[got]));
        if (got > 0) chk("b2b_gap", 96'(cyc - last), 96'd50);
        last = cyc;
        got++;
      end else begin
        chk("b2b_idle", quotient | 96'(remainder) | 96'(div_zero), 96'd0);
      end
      if (in_ready) begin
        if (issued < 3) begin
          dividend = ops_a[issued]; divisor = ops_b[issued]; issued++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        dividend = {$urandom, $urandom, $urandom};
        divisor  = {16'($urandom), 32'($urandom)};
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 96'(got), 96'd3);

    // reset during CALC drops the result
    @(negedge clk);
    in_valid = 1'b1; dividend = 96'd1000; divisor = 48'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", 96'(in_ready), 96'd1);
    chk("mrst_out", 96'({out_valid, div_zero}) | quotient | 96'(remainder), 96'd0);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("mrst_nopulse", 96'(pulses), 96'd0);
    run_op("d9_4", 96'd9, 48'd4, 96'd2, 48'd1, 1'b0, 49);

    // reset wins over a simultaneous in_valid
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; dividend = 96'd50; divisor = 48'd5;
    @(posedge clk);
    #1 begin rst = 1'b0; in_valid = 1'b0; end
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid || !in_ready) pulses++;
    end
    chk("rstv_noaccept", 96'(pulses), 96'd0);

    for (int k = 0; k < 200; k++) begin
      ra = {$urandom, $urandom, $urandom} >> $urandom_range(95, 0);
      rb = {16'($urandom), 32'($urandom)} >> $urandom_range(47, 0);
      if (rb == '0) begin
        run_op("rnd_dz", ra, rb, '1, ra[47:0], 1'b1, 1);
      end else begin
        rq = ra / 96'(rb);
        rr = 48'(ra % 96'(rb));
        run_op("rnd", ra, rb, rq, rr, 1'b0, 49);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
